// File: rtl/demux2_16bit_buf_pkg.sv
// Shared constants for the 16-bit mux/demux datapath.
// Widths and lane indices are shared with the 2:1 word mux.
package demux_pkg;

   localparam int W_DEF  = 16;
   localparam int CW_DEF = 8;

   localparam logic LANE0 = 1'b0;
   localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/demux2_16bit_buf_if.sv
// Source-side and two-lane sink-side handshake bundle.
// slave is the demux view, master is the source/sink view.
interface demux2_16bit_buf_if
   import demux_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int CW = CW_DEF
);

   logic [W-1:0]  in;
   logic          s;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  out0;
   logic          out0_valid;
   logic          out0_ready;
   logic [W-1:0]  out1;
   logic          out1_valid;
   logic          out1_ready;
   logic [CW-1:0] cnt0;
   logic [CW-1:0] cnt1;

   modport slave (
      input  in, s, in_valid, out0_ready, out1_ready,
      output in_ready, out0, out0_valid, out1, out1_valid,
      output cnt0, cnt1
   );

   modport master (
      output in, s, in_valid, out0_ready, out1_ready,
      input  in_ready, out0, out0_valid, out1, out1_valid,
      input  cnt0, cnt1
   );

endinterface

// File: rtl/demux2_16bit_buf_lane.sv
// One output lane: holding register, valid flag and
// transfer counter.
module demux_lane
   import demux_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [W-1:0]  d,
   input  logic          ready,
   output logic [W-1:0]  q,
   output logic          valid,
   output logic [CW-1:0] cnt,
   output logic          free
);

   logic [W-1:0]  q_q, q_d;
   logic          valid_q, valid_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // A load wins over a drain so back-to-back words keep valid high.
   always_comb begin
      q_d     = q_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      if (load) begin
         q_d     = d;
         valid_d = 1'b1;
         cnt_d   = cnt_q + CW'(1);
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q     <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         q_q     <= q_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign q     = q_q;
   assign valid = valid_q;
   assign cnt   = cnt_q;
   assign free  = !valid_q || ready;

endmodule

// File: rtl/demux2_16bit_buf.sv
// Buffered 1-to-2 word demux: steers each accepted word
// into one of two independently drained lanes.
module demux2_16bit_buf
   import demux_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int CW = CW_DEF
) (
   input logic                clk,
   input logic                rst_n,
   demux2_16bit_buf_if.slave  bus
);

   logic sel;
   logic acc;
   logic load0, load1;
   logic free0, free1;
   wire  sel_n, nd0, nd1, rdy;

   assign sel = bus.s;

   // in_ready = sel ? free1 : free0, as a nand-nand mux.
   not  u_inv  (sel_n, sel);
   nand u_nd0  (nd0, free0, sel_n);
   nand u_nd1  (nd1, free1, sel);
   nand u_nd2  (rdy, nd0, nd1);

   assign bus.in_ready = rdy;

   assign acc   = bus.in_valid && rdy;
   assign load0 = acc && (sel == LANE0);
   assign load1 = acc && (sel == LANE1);

   demux_lane #(.W(W), .CW(CW)) u_lane0 (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load0),
      .d     (bus.in),
      .ready (bus.out0_ready),
      .q     (bus.out0),
      .valid (bus.out0_valid),
      .cnt   (bus.cnt0),
      .free  (free0)
   );

   demux_lane #(.W(W), .CW(CW)) u_lane1 (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load1),
      .d     (bus.in),
      .ready (bus.out1_ready),
      .q     (bus.out1),
      .valid (bus.out1_valid),
      .cnt   (bus.cnt1),
      .free  (free1)
   );

endmodule

// File: doc/demux2_16bit_buf.md
# demux2_16bit_buf

Buffered 1-to-2 demultiplexer for the 16-bit datapath: the receiving end of the 2:1 word mux. It takes one 16-bit word per handshake from a single source and steers it, by select `s`, into one of two output lanes. Each lane holds the word in a one-entry register until its consumer accepts it. It sits between a shared result bus and two independent destinations, such as the register-file write port and the memory write buffer, so that a stalled destination never corrupts the other lane.

## Interface
Parameters:
- `W`, 16: data width.
- `CW`, 8: width of per-lane transfer counters.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: synchronous reset, active-low, sampled on rising `clk`.
- `in` input W: data word from source.
- `s` input 1: lane select; 0 steers to lane 0, 1 to lane 1.
- `in_valid` input 1: source has a word on `in`/`s`.
- `in_ready` output 1: block accepts the word this cycle.
- `out0` output W: lane 0 held word.
- `out0_valid` output 1: lane 0 holds a word.
- `out0_ready` input 1: lane 0 consumer takes word this cycle.
- `out1`, `out1_valid`, `out1_ready`: same as the lane 0 ports, for lane 1.
- `cnt0` output CW: words accepted into lane 0, modulo 2^CW.
- `cnt1` output CW: words accepted into lane 1, modulo 2^CW.

## Operation
- Accept: an input transfer occurs on a cycle with `in_valid && in_ready`. Only the lane selected by `s` loads `in`; the other lane's register, valid and counter are untouched.
- `in_ready` is combinational and equals `!outS_valid || outS_ready`, where S is the lane named by the current `s`. It does not depend on `in_valid`.
- Lane load: at the edge, `outS` gets `in`, `outS_valid` gets 1, and `cntS` gets `cntS+1`.
- Lane drain: when `outK_valid && outK_ready` and there is no load into lane K, `outK_valid` gets 0. `outK` data keeps its last value (don't-care when invalid, but must not glitch).
- Simultaneous drain and load on the same lane: the new word replaces the old, `outK_valid` stays 1, and the counter increments. This gives full throughput, one word per cycle per lane.
- Simultaneous drain of lane 0 and load of lane 1 (or the reverse): both actions occur independently.
- Counters wrap from 2^CW-1 to 0 with no flag.
- Source rules: while `in_valid && !in_ready`, the source holds `in` and `s` stable. It may change `s` only between transfers.
- Sink rules: while `outK_valid && !outK_ready`, `outK` and `outK_valid` are stable, guaranteed by the block.
- `outK_ready` asserted while `outK_valid`=0 has no effect.

## Timing
- Reset (`rst_n`=0 at an edge) forces `out0`=`out1`=0, `out0_valid`=`out1_valid`=0, and `cnt0`=`cnt1`=0. Reset overrides any simultaneous load or drain.
- During reset, `in_ready` reads 1 because both lanes are empty; any word presented is discarded.
- Reset mid-operation drops held words silently. The first accept after release is counted as 1.
- Latency: a word accepted at edge N appears on `outS` with `outS_valid`=1 immediately after edge N, one cycle after presentation.
- Combinational paths: from `s`, `out0_ready`, `out1_ready`, `out0_valid`, `out1_valid` to `in_ready` only. There is no path from `in` or `in_valid` to any output.

## Structure
- Shared package `demux_pkg` holds the `W`/`CW` default constants and lane-index constants `LANE0`=0 and `LANE1`=1, shared with the 16-bit mux datapath.
- Sub-module `demux_lane` (parameters W, CW) contains one holding register, its valid flag and its counter. Its ports are `clk`, `rst_n`, `load`, `d`, `ready`, `q`, `valid`, `cnt`, and `free` (= `!valid || ready`). The top instantiates it twice.
- Top-level steering: `load0 = in_valid && in_ready && !s` and `load1 = in_valid && in_ready && s`. `in_ready` is a 2:1 select of `free0`/`free1` by `s`, built from the team's not/nand gate primitives.

## Test plan
- Reset then idle: after `rst_n` low for 2 cycles, all outputs 0 and `in_ready`=1.
- Single steer: `in`=16'hA5A5, `s`=0, `in_valid`=1 for 1 cycle with `out0_ready`=0 gives `out0`=A5A5, `out0_valid`=1, `cnt0`=1, `out1_valid`=0, `cnt1`=0. The word is held for 5 cycles.
- Backpressure isolation: with lane 0 full and `out0_ready`=0, set `s`=0 and check `in_ready`=0. Set `s`=1 with `in`=16'h1234: the word is accepted to lane 1 while lane 0 still holds A5A5.
- Streaming with simultaneous drain and load: hold `out1_ready`=1 and send 4 words 0001..0004 to lane 1 back-to-back. Check `in_ready`=1 every cycle, `out1` steps 0001..0004 one cycle later, and `cnt1` increases by 4.
- Counter wrap: 256 accepts into lane 0 with `cnt0` starting at 0 give `cnt0`=0 and leave `cnt1` unchanged.
- Mid-operation reset: with both lanes full, pulse `rst_n`=0 for 1 cycle. Check valids=0, counters=0, and that the next accept to lane 1 gives `cnt1`=1.
